// File: rtl/gpu_line_fetch.sv
// Scanline fetcher: pulls one planar RGB framebuffer row per refill into a
// back buffer and presents the previously fetched row on hline_r/g/b.
module gpu_line_fetch #(
    parameter int LINE_PX    = 320,
    parameter int V_LINES    = 480,
    parameter int LINE_SHIFT = 1,
    parameter int ADDR_W     = 22
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              refill,
    input  logic [9:0]        line,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [LINE_PX-1:0] hline_r,
    output logic [LINE_PX-1:0] hline_g,
    output logic [LINE_PX-1:0] hline_b,
    output logic              busy,
    output logic              overrun
);

    localparam int WPL         = LINE_PX / 32;
    localparam int PLANE_WORDS = WPL * (V_LINES >> LINE_SHIFT);
    localparam int WW          = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t       state, nxt_state;
    logic [1:0]   plane, nxt_plane;
    logic [WW-1:0] word, nxt_word;
    logic [9:0]   row, nxt_row;

    logic [LINE_PX-1:0] back_r, back_g, back_b;

    logic [10:0] nxt_line;
    logic [9:0]  refill_row;
    logic        accept;
    logic        last_word;
    logic        done;

    assign nxt_line   = {1'b0, line} + 11'd1;
    assign refill_row = (nxt_line >= 11'(V_LINES)) ? 10'd0
                      : 10'(nxt_line[9:0] >> LINE_SHIFT);
    assign accept     = (state == FETCH) && mem_ready;
    assign last_word  = (word == WW'(WPL - 1));
    assign done       = accept && (plane == 2'd2) && last_word;

    // State and fetch counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            plane <= 2'd0;
            word  <= '0;
            row   <= 10'd0;
        end else begin
            state <= nxt_state;
            plane <= nxt_plane;
            word  <= nxt_word;
            row   <= nxt_row;
        end
    end

    // Next state: refill restarts the fetch, otherwise walk words then planes
    always_comb begin
        nxt_state = state;
        nxt_plane = plane;
        nxt_word  = word;
        nxt_row   = row;
        if (refill) begin
            nxt_state = FETCH;
            nxt_plane = 2'd0;
            nxt_word  = '0;
            nxt_row   = refill_row;
        end else if (accept) begin
            if (done) begin
                nxt_state = IDLE;
                nxt_plane = 2'd0;
                nxt_word  = '0;
            end else if (last_word) begin
                nxt_word  = '0;
                nxt_plane = plane + 2'd1;
            end else begin
                nxt_word  = word + WW'(1);
            end
        end
    end

    // Request strobe follows the registered state bit
    always_comb begin
        mem_valid = (state == FETCH);
        busy      = (state == FETCH);
    end

    // Address only moves on restart or accept, so it holds through stalls
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_addr <= '0;
        end else if (refill || accept) begin
            mem_addr <= fb_base
                      + ADDR_W'(nxt_plane) * ADDR_W'(PLANE_WORDS)
                      + ADDR_W'(nxt_row) * ADDR_W'(WPL)
                      + ADDR_W'(nxt_word);
        end
    end

    // Back buffer fill from accepted read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            back_r <= '0;
            back_g <= '0;
            back_b <= '0;
        end else if (accept) begin
            case (plane)
                2'd0:    back_r[{word, 5'd0} +: 32] <= mem_rdata;
                2'd1:    back_g[{word, 5'd0} +: 32] <= mem_rdata;
                default: back_b[{word, 5'd0} +: 32] <= mem_rdata;
            endcase
        end
    end

    // Front buffer swap on refill; overrun latches a restart of a live fetch
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hline_r <= '0;
            hline_g <= '0;
            hline_b <= '0;
            overrun <= 1'b0;
        end else if (refill) begin
            hline_r <= back_r;
            hline_g <= back_g;
            hline_b <= back_b;
            if (state == FETCH) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpu_line_fetch.sv
// Directed bench for gpu_line_fetch: memory returns data equal to the
// requested address so every buffer word identifies its source.
module tb_gpu_line_fetch;

    localparam int AW  = 22;
    localparam int PX  = 320;
    localparam int PW  = 2400;
    localparam int WPL = 10;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] fb_base;
    logic          refill;
    logic [9:0]    line;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [PX-1:0] hline_r, hline_g, hline_b;
    logic          busy;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] fb;
        logic [9:0]    line;
        int            row;
    } vec_t;

    vec_t tbl[6];

    assign mem_rdata = {10'd0, mem_addr};

    always #5 clk = ~clk;

    gpu_line_fetch dut (
        .clk       (clk),
        .resetn    (resetn),
        .fb_base   (fb_base),
        .refill    (refill),
        .line      (line),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hline_r   (hline_r),
        .hline_g   (hline_g),
        .hline_b   (hline_b),
        .busy      (busy),
        .overrun   (overrun)
    );

    function automatic logic [AW-1:0] ea(input logic [AW-1:0] fb,
                                         input int row, input int k);
        return fb + AW'((k / WPL) * PW + row * WPL + (k % WPL));
    endfunction

    function automatic logic [31:0] bk(input logic [AW-1:0] fb,
                                       input int row, input int p,
                                       input int w);
        return {10'd0, ea(fb, row, p * WPL + w)};
    endfunction

    function automatic logic [31:0] wd(input logic [PX-1:0] v, input int w);
        return v[w*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_refill(input logic [9:0] ln);
        refill = 1'b1;
        line   = ln;
        tick();
        refill = 1'b0;
    endtask

    task automatic stream(input logic [AW-1:0] fb, input int row,
                          input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            chk($sformatf("req row%0d k%0d", row, k),
                64'({mem_valid, busy, mem_addr}),
                64'({1'b1, 1'b1, ea(fb, row, k)}));
            tick();
        end
    endtask

    logic [AW-1:0] pfb;
    int            prow;
    logic [AW-1:0] F;

    initial begin
        resetn    = 1'b0;
        refill    = 1'b0;
        line      = 10'd0;
        mem_ready = 1'b1;
        fb_base   = 22'h000100;
        F         = 22'h000100;
        pfb       = '0;
        prow      = 0;
        tick();
        tick();
        chk("reset ctl", 64'({mem_valid, busy, overrun, mem_addr}), 64'(0));
        chk("reset hline", 64'(|{hline_r, hline_g, hline_b}), 64'(0));
        resetn = 1'b1;
        tick();

        tbl[0] = '{fb: 22'h000100, line: 10'd0,   row: 0};
        tbl[1] = '{fb: 22'h000100, line: 10'd479, row: 0};
        tbl[2] = '{fb: 22'h000100, line: 10'd2,   row: 1};
        tbl[3] = '{fb: 22'h000100, line: 10'd477, row: 239};
        tbl[4] = '{fb: 22'h3FF000, line: 10'd100, row: 50};
        tbl[5] = '{fb: 22'h000100, line: 10'd3,   row: 2};

        for (int i = 0; i < 6; i++) begin
            fb_base = tbl[i].fb;
            do_refill(tbl[i].line);
            chk($sformatf("v%0d overrun", i), 64'(overrun), 64'(0));
            chk($sformatf("v%0d r.w0", i), 64'(wd(hline_r, 0)),
                64'((i == 0) ? 32'd0 : bk(pfb, prow, 0, 0)));
            chk($sformatf("v%0d g.w0", i), 64'(wd(hline_g, 0)),
                64'((i == 0) ? 32'd0 : bk(pfb, prow, 1, 0)));
            chk($sformatf("v%0d b.w9", i), 64'(wd(hline_b, 9)),
                64'((i == 0) ? 32'd0 : bk(pfb, prow, 2, 9)));
            stream(tbl[i].fb, tbl[i].row, 0, 30);
            chk($sformatf("v%0d idle", i), 64'({mem_valid, busy}), 64'(0));
            pfb  = tbl[i].fb;
            prow = tbl[i].row;
        end

        // Stall: request must hold, a single pulse writes a single word
        mem_ready = 1'b0;
        do_refill(10'd8);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall %0d", i), 64'({mem_valid, mem_addr}),
                64'({1'b1, ea(F, 4, 0)}));
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("stall adv", 64'({mem_valid, mem_addr}), 64'({1'b1, ea(F, 4, 1)}));
        tick();
        chk("stall hold", 64'({mem_valid, mem_addr}), 64'({1'b1, ea(F, 4, 1)}));
        do_refill(10'd10);
        chk("stall ovr", 64'(overrun), 64'(1));
        chk("stall r.w0", 64'(wd(hline_r, 0)), 64'(bk(F, 4, 0, 0)));
        chk("stall r.w1", 64'(wd(hline_r, 1)), 64'(bk(pfb, prow, 0, 1)));

        // Restart at word 12 while that word is also being accepted
        mem_ready = 1'b1;
        stream(F, 5, 0, 12);
        chk("w12 addr", 64'(mem_addr), 64'(ea(F, 5, 12)));
        do_refill(10'd20);
        chk("w12 ovr", 64'(overrun), 64'(1));
        chk("w12 r.w0", 64'(wd(hline_r, 0)), 64'(bk(F, 5, 0, 0)));
        chk("w12 r.w9", 64'(wd(hline_r, 9)), 64'(bk(F, 5, 0, 9)));
        chk("w12 g.w1", 64'(wd(hline_g, 1)), 64'(bk(F, 5, 1, 1)));
        chk("w12 g.w2", 64'(wd(hline_g, 2)), 64'(bk(pfb, prow, 1, 2)));
        chk("w12 b.w0", 64'(wd(hline_b, 0)), 64'(bk(pfb, prow, 2, 0)));
        stream(F, 10, 0, 30);
        chk("w12 idle", 64'({mem_valid, busy}), 64'(0));
        do_refill(10'd0);
        chk("sticky ovr", 64'(overrun), 64'(1));
        chk("sticky g.w2", 64'(wd(hline_g, 2)), 64'(bk(F, 10, 1, 2)));

        // Reset in the middle of a fetch
        stream(F, 0, 0, 7);
        resetn = 1'b0;
        tick();
        chk("rst ctl", 64'({mem_valid, busy, overrun, mem_addr}), 64'(0));
        chk("rst hline", 64'(|{hline_r, hline_g, hline_b}), 64'(0));
        resetn = 1'b1;
        repeat (5) tick();
        chk("rst quiet", 64'({mem_valid, busy}), 64'(0));
        do_refill(10'd0);
        chk("rst back", 64'(|{hline_r, hline_g, hline_b}), 64'(0));
        chk("rst ovr", 64'(overrun), 64'(0));
        stream(F, 0, 0, 30);
        do_refill(10'd0);
        chk("post r.w0", 64'(wd(hline_r, 0)), 64'(bk(F, 0, 0, 0)));
        chk("post b.w9", 64'(wd(hline_b, 9)), 64'(bk(F, 0, 2, 9)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
